// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared constants and types for the 4-bit ALU sequencer: opcode values,
//   FSM state type, data width and the iteration count used by the
//   multi-cycle multiply/divide path.
//   Build option: ALU_SEQ_FAST_MUL_EN moves multiply onto the single-cycle
//   path; divide and modulo always iterate.
package alu_seq_pkg;

  localparam int DATA_W = 4;
  localparam int ITER_N = 4;
  localparam int CNT_W  = 2;

  localparam logic [3:0] OP_INC  = 4'h0;
  localparam logic [3:0] OP_DEC  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_RSUB = 4'h4;
  localparam logic [3:0] OP_MUL  = 4'h5;
  localparam logic [3:0] OP_DIV  = 4'h6;
  localparam logic [3:0] OP_MOD  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_NOTA = 4'hA;
  localparam logic [3:0] OP_NOTB = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_NOR  = 4'hD;
  localparam logic [3:0] OP_XOR  = 4'hE;
  localparam logic [3:0] OP_XNOR = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True for opcodes that spend ITER_N cycles in EXEC.
  function automatic logic is_iter_op(input logic [3:0] op);
`ifdef ALU_SEQ_FAST_MUL_EN
    return (op == OP_DIV) || (op == OP_MOD);
`else
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
`endif
  endfunction

endpackage

// File: rtl/alu_seq_iter_unit.sv
// alu_seq_iter_unit
//   Bit-serial multiply (shift-add, LSB of B first) and restoring divide
//   (MSB of A first), one operand bit per step.  The *_nxt outputs are the
//   values after the current step, so the caller can capture the final
//   answer on the same edge that performs the last step.
// Ports
//   clk, rst_n       clock, async active-low reset
//   start            clear the accumulators (command accepted)
//   step             perform iteration cnt
//   cnt              iteration index 0..3
//   a, b             latched operands
//   mul_nxt          low 5 bits of the partial product after this step
//   quo_nxt, rem_nxt quotient / remainder after this step
module alu_seq_iter_unit
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic [CNT_W-1:0]  cnt,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W:0]   mul_nxt,
  output logic [DATA_W-1:0] quo_nxt,
  output logic [DATA_W-1:0] rem_nxt
);

  logic [DATA_W:0]   acc_q, acc_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;

  logic [DATA_W:0]   addend;
  logic [DATA_W:0]   rem_sh;
  logic              bit_in;
  logic              q_bit;

  always_comb begin
    addend  = b[cnt] ? ({1'b0, a} << cnt) : '0;
    mul_nxt = acc_q + addend;

    // Partial remainder never exceeds 2*B-1, so 5 bits hold the shifted
    // value and the difference always fits back into 4 bits.  With B=0 the
    // subtract is a no-op, which naturally yields quotient F, remainder A.
    bit_in = a[2'd3 - cnt];
    rem_sh = {rem_q, bit_in};
    q_bit  = (rem_sh >= {1'b0, b});
    rem_nxt = q_bit ? (rem_sh[DATA_W-1:0] - b) : rem_sh[DATA_W-1:0];
    quo_nxt = {quo_q[DATA_W-2:0], q_bit};

    acc_d = acc_q;
    rem_d = rem_q;
    quo_d = quo_q;
    if (start) begin
      acc_d = '0;
      rem_d = '0;
      quo_d = '0;
    end else if (step) begin
      acc_d = mul_nxt;
      rem_d = rem_nxt;
      quo_d = quo_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
    end else begin
      acc_q <= acc_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

endmodule

// File: rtl/alu_sequencer_4_bit.sv
// alu_sequencer_4_bit
//   4-bit ALU with a valid/ready command port and a held response port.
//   Single-cycle ops finish one edge after accept; multiply/divide/modulo
//   iterate for four cycles in alu_seq_iter_unit.
//   Build option: ALU_SEQ_FAST_MUL_EN computes multiply combinationally
//   with single-cycle latency; results are identical.
// Ports
//   Clock_In, Reset_n_In                 clock, async active-low reset
//   Cmd_Valid_In / Cmd_Ready_Out         command handshake (ready in IDLE)
//   Cmd_Opcode_In, Cmd_Data_A/B_In       opcode and operands
//   Rsp_Valid_Out / Rsp_Ready_In         response handshake (valid in DONE)
//   Rsp_Result_Out, Rsp_*_Out            registered result and flags
//   Busy_Out                             state is not IDLE
//
// state   | meaning
// IDLE    | waiting for a command, ready high
// EXEC    | computing; 1 cycle or 4 iterations
// DONE    | response held until consumer takes it
module alu_sequencer_4_bit
  import alu_seq_pkg::*;
(
  input  logic              Clock_In,
  input  logic              Reset_n_In,
  input  logic              Cmd_Valid_In,
  output logic              Cmd_Ready_Out,
  input  logic [DATA_W-1:0] Cmd_Opcode_In,
  input  logic [DATA_W-1:0] Cmd_Data_A_In,
  input  logic [DATA_W-1:0] Cmd_Data_B_In,
  output logic              Rsp_Valid_Out,
  input  logic              Rsp_Ready_In,
  output logic [DATA_W-1:0] Rsp_Result_Out,
  output logic              Rsp_Carry_Out,
  output logic              Rsp_Zero_Out,
  output logic              Rsp_Div_Zero_Out,
  output logic              Busy_Out
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               dz_q, dz_d;

  logic               iter_start;
  logic               iter_step;
  logic [DATA_W:0]    iter_mul;
  logic [DATA_W-1:0]  iter_quo;
  logic [DATA_W-1:0]  iter_rem;

  logic [DATA_W:0]    calc5;
  logic               calc_dz;
  logic [DATA_W:0]    ext_a;
  logic [DATA_W:0]    ext_b;

`ifdef ALU_SEQ_FAST_MUL_EN
  logic [DATA_W:0]    fast_prod;
  assign fast_prod = ext_a * ext_b;
`endif

  alu_seq_iter_unit u_iter (
    .clk     (Clock_In),
    .rst_n   (Reset_n_In),
    .start   (iter_start),
    .step    (iter_step),
    .cnt     (cnt_q),
    .a       (a_q),
    .b       (b_q),
    .mul_nxt (iter_mul),
    .quo_nxt (iter_quo),
    .rem_nxt (iter_rem)
  );

  // Result datapath.  Bit 4 of calc5 is the carry; non-arithmetic ops
  // leave it 0 so the carry flag needs no per-op special case.
  always_comb begin
    ext_a   = {1'b0, a_q};
    ext_b   = {1'b0, b_q};
    calc5   = '0;
    calc_dz = 1'b0;
    case (op_q)
      OP_INC:  calc5 = ext_a + 5'd1;
      OP_DEC:  calc5 = ext_a - 5'd1;
      OP_ADD:  calc5 = ext_a + ext_b;
      OP_SUB:  calc5 = ext_a - ext_b;
      OP_RSUB: calc5 = ext_b - ext_a;
`ifdef ALU_SEQ_FAST_MUL_EN
      OP_MUL:  calc5 = fast_prod;
`else
      OP_MUL:  calc5 = iter_mul;
`endif
      OP_DIV: begin
        calc5   = {1'b0, iter_quo};
        calc_dz = (b_q == '0);
      end
      OP_MOD: begin
        calc5   = {1'b0, iter_rem};
        calc_dz = (b_q == '0);
      end
      OP_AND:  calc5 = {1'b0, a_q & b_q};
      OP_OR:   calc5 = {1'b0, a_q | b_q};
      OP_NOTA: calc5 = {1'b0, ~a_q};
      OP_NOTB: calc5 = {1'b0, ~b_q};
      OP_NAND: calc5 = {1'b0, ~(a_q & b_q)};
      OP_NOR:  calc5 = {1'b0, ~(a_q | b_q)};
      OP_XOR:  calc5 = {1'b0, a_q ^ b_q};
      OP_XNOR: calc5 = {1'b0, ~(a_q ^ b_q)};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = rsp_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    dz_d        = dz_q;
    iter_start  = 1'b0;
    iter_step   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Cmd_Valid_In) begin
          op_d       = Cmd_Opcode_In;
          a_d        = Cmd_Data_A_In;
          b_d        = Cmd_Data_B_In;
          cnt_d      = '0;
          iter_start = 1'b1;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        iter_step = is_iter_op(op_q);
        if (!is_iter_op(op_q) || (cnt_q == CNT_W'(ITER_N - 1))) begin
          rsp_valid_d = 1'b1;
          result_d    = calc5[DATA_W-1:0];
          carry_d     = calc5[DATA_W];
          zero_d      = (calc5[DATA_W-1:0] == '0);
          dz_d        = calc_dz;
          cnt_d       = '0;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_DONE: begin
        if (Rsp_Ready_In) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      dz_q        <= dz_d;
    end
  end

  assign Cmd_Ready_Out    = (state_q == ST_IDLE);
  assign Busy_Out         = (state_q != ST_IDLE);
  assign Rsp_Valid_Out    = rsp_valid_q;
  assign Rsp_Result_Out   = result_q;
  assign Rsp_Carry_Out    = carry_q;
  assign Rsp_Zero_Out     = zero_q;
  assign Rsp_Div_Zero_Out = dz_q;

endmodule

// File: tb/tb_alu_sequencer_4_bit.sv
// Testbench for alu_sequencer_4_bit: directed vectors with hand-computed
// expectations, plus a per-cycle monitor comparing any held response to a
// plain-arithmetic model of the opcode table.
module tb_alu_sequencer_4_bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_zero;
  logic       rsp_dz;
  logic       busy;

  int n_vec  = 0;
  int n_fail = 0;

  // model expectations for the command in flight
  logic exp_live = 1'b0;
  int   exp_r, exp_c, exp_z, exp_dz;

  typedef struct {
    int op; int a; int b; int hold;
    int r;  int c; int z; int dz;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  alu_sequencer_4_bit dut (
    .Clock_In         (clk),
    .Reset_n_In       (rst_n),
    .Cmd_Valid_In     (cmd_valid),
    .Cmd_Ready_Out    (cmd_ready),
    .Cmd_Opcode_In    (cmd_op),
    .Cmd_Data_A_In    (cmd_a),
    .Cmd_Data_B_In    (cmd_b),
    .Rsp_Valid_Out    (rsp_valid),
    .Rsp_Ready_In     (rsp_ready),
    .Rsp_Result_Out   (rsp_result),
    .Rsp_Carry_Out    (rsp_carry),
    .Rsp_Zero_Out     (rsp_zero),
    .Rsp_Div_Zero_Out (rsp_dz),
    .Busy_Out         (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Behavioural model: the opcode table in plain integer arithmetic.
  function automatic void model(input int op, input int a, input int b,
                                output int r, output int c, output int dz);
    int v;
    v = 0; c = 0; dz = 0; r = 0;
    case (op)
      0, 1, 2, 3, 4: begin
        if (op == 0) v = a + 1;
        else if (op == 1) v = a - 1;
        else if (op == 2) v = a + b;
        else if (op == 3) v = a - b;
        else v = b - a;
        r = (v + 32) % 16;
        c = (v < 0 || v > 15) ? 1 : 0;
      end
      5: begin
        v = a * b;
        r = v % 16;
        c = (v / 16) % 2;
      end
      6: begin r = (b == 0) ? 15 : a / b; dz = (b == 0) ? 1 : 0; end
      7: begin r = (b == 0) ? a : a % b;  dz = (b == 0) ? 1 : 0; end
      8:  r = a & b;
      9:  r = a | b;
      10: r = 15 - a;
      11: r = 15 - b;
      12: r = 15 - (a & b);
      13: r = 15 - (a | b);
      14: r = a ^ b;
      default: r = 15 - (a ^ b);
    endcase
  endfunction

  function automatic int model_latency(input int op);
    if (op == 6 || op == 7) return 4;
`ifdef ALU_SEQ_FAST_MUL_EN
    if (op == 5) return 1;
`else
    if (op == 5) return 4;
`endif
    return 1;
  endfunction

  // Every cycle: no response without a command in flight; any held
  // response must match the model and keep the command port closed.
  always @(negedge clk) begin
    if (!exp_live) begin
      check("stray_rsp_valid", rsp_valid, 0);
    end else if (rsp_valid) begin
      check("mon_result", rsp_result, exp_r);
      check("mon_carry",  rsp_carry,  exp_c);
      check("mon_zero",   rsp_zero,   exp_z);
      check("mon_divzero", rsp_dz,    exp_dz);
      check("mon_ready_in_done", cmd_ready, 0);
      check("mon_busy_in_done",  busy, 1);
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 20 && !cmd_ready; i++) begin
      @(posedge clk); #1;
    end
    check("cmd_ready_timeout", cmd_ready, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    int m_c, m_dz;
    wait_ready();
    model(v.op, v.a, v.b, exp_r, m_c, m_dz);
    exp_c = m_c; exp_dz = m_dz; exp_z = (exp_r == 0) ? 1 : 0;
    exp_live  = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = 4'(v.op); cmd_a = 4'(v.a); cmd_b = 4'(v.b);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 4'($urandom); cmd_a = 4'($urandom); cmd_b = 4'($urandom);
    check("busy_after_accept", busy, 1);
    check("ready_after_accept", cmd_ready, 0);
    lat = 0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) lat = k;
    end
    check($sformatf("latency_op%0d", v.op), lat, model_latency(v.op));
    check($sformatf("result_op%0d_%0d_%0d", v.op, v.a, v.b), rsp_result, v.r);
    check($sformatf("carry_op%0d", v.op), rsp_carry, v.c);
    check($sformatf("zero_op%0d", v.op), rsp_zero, v.z);
    check($sformatf("divzero_op%0d", v.op), rsp_dz, v.dz);
    for (int i = 0; i < v.hold; i++) begin
      cmd_valid = 1'b1;
      cmd_op = 4'h2; cmd_a = 4'(i); cmd_b = 4'h3;
      @(posedge clk); #1;
      check("hold_valid", rsp_valid, 1);
      check("hold_result", rsp_result, v.r);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_live  = 1'b0;
    check("rsp_taken_valid", rsp_valid, 0);
    check("idle_ready", cmd_ready, 1);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0;
    #12;
    check("reset_valid",  rsp_valid, 0);
    check("reset_result", rsp_result, 0);
    check("reset_flags",  {rsp_carry, rsp_zero, rsp_dz}, 0);
    check("reset_busy",   busy, 0);
    check("reset_ready",  cmd_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    //                 op  a   b  hold r   c  z  dz
    vecs.push_back('{ 2,  9,  8, 0,  1,  1, 0, 0});
    vecs.push_back('{ 1,  0,  6, 0, 15,  1, 0, 0});
    vecs.push_back('{ 3,  4,  4, 0,  0,  0, 1, 0});
    vecs.push_back('{ 5,  7,  5, 0,  3,  0, 0, 0});
    vecs.push_back('{ 6, 13,  0, 0, 15,  0, 0, 1});
    vecs.push_back('{ 7, 13,  0, 0, 13,  0, 0, 1});
    vecs.push_back('{ 7, 13,  4, 0,  1,  0, 0, 0});
    vecs.push_back('{ 6, 13,  4, 0,  3,  0, 0, 0});
    vecs.push_back('{ 0, 15,  0, 0,  0,  1, 1, 0});
    vecs.push_back('{ 4,  3,  5, 0,  2,  0, 0, 0});
    vecs.push_back('{ 4,  5,  3, 0, 14,  1, 0, 0});
    vecs.push_back('{ 3,  2,  7, 0, 11,  1, 0, 0});
    vecs.push_back('{ 5, 15, 15, 0,  1,  0, 0, 0});
    vecs.push_back('{ 5,  6,  3, 0,  2,  1, 0, 0});
    vecs.push_back('{ 8, 12, 10, 0,  8,  0, 0, 0});
    vecs.push_back('{ 9, 12, 10, 0, 14,  0, 0, 0});
    vecs.push_back('{10,  5,  9, 0, 10,  0, 0, 0});
    vecs.push_back('{11,  9,  5, 0, 10,  0, 0, 0});
    vecs.push_back('{12, 12, 10, 0,  7,  0, 0, 0});
    vecs.push_back('{13, 12, 10, 0,  1,  0, 0, 0});
    vecs.push_back('{14, 12, 10, 0,  6,  0, 0, 0});
    vecs.push_back('{15, 12, 10, 0,  9,  0, 0, 0});
    vecs.push_back('{14,  5,  5, 0,  0,  0, 1, 0});
    vecs.push_back('{ 2,  9,  8, 3,  1,  1, 0, 0});
    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during iteration 2 of a divide: command must vanish.
    wait_ready();
    exp_live  = 1'b0;
    cmd_valid = 1'b1; cmd_op = 4'h6; cmd_a = 4'd13; cmd_b = 4'd4;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midreset_valid",  rsp_valid, 0);
    check("midreset_result", rsp_result, 0);
    check("midreset_flags",  {rsp_carry, rsp_zero, rsp_dz}, 0);
    check("midreset_busy",   busy, 0);
    check("midreset_ready",  cmd_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("post_reset_valid", rsp_valid, 0);
    end
    check("post_reset_busy", busy, 0);

    run_vec('{7, 13, 4, 1, 1, 0, 0, 0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_sequencer_4_bit.md
ALU_SEQUENCER_4_BIT -- requirements
Module: alu_sequencer_4_bit

Interface
REQ-001 Parameters SHALL be none; data width SHALL be fixed at 4 bits.
REQ-002 Clock_In  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Reset_n_In  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Cmd_Valid_In  input  1  SHALL mean a command is offered.
REQ-005 Cmd_Ready_Out  output  1  SHALL mean the block accepts a command this cycle.
REQ-006 Cmd_Opcode_In  input  4  SHALL select the operation: 0 A+1, 1 A-1, 2 A+B, 3 A-B, 4 B-A, 5 A*B, 6 A/B, 7 A%B, 8 AND, 9 OR, A NOT A, B NOT B, C NAND, D NOR, E XOR, F XNOR.
REQ-007 Cmd_Data_A_In / Cmd_Data_B_In  input  4 each  SHALL be operands A and B.
REQ-008 Rsp_Valid_Out  output  1  SHALL mean a response is held.
REQ-009 Rsp_Ready_In  input  1  SHALL mean the consumer takes the response.
REQ-010 Rsp_Result_Out  output  4; Rsp_Carry_Out, Rsp_Zero_Out, Rsp_Div_Zero_Out  output  1 each  SHALL be the registered result and flags.
REQ-011 Busy_Out  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-012 FSM states SHALL be IDLE, EXEC, DONE; Cmd_Ready_Out SHALL be high exactly in IDLE.
REQ-013 A command SHALL be accepted on an edge with Cmd_Valid_In and Cmd_Ready_Out high; opcode and operands SHALL be latched on that edge and the state SHALL go IDLE->EXEC.
REQ-014 Opcodes 0-4 and 8-F SHALL complete in one EXEC cycle: accept at edge N, Rsp_Valid_Out high after edge N+1.
REQ-015 Opcodes 5, 6, 7 SHALL iterate over a 2-bit counter (0..3), one bit per cycle: shift-add multiply, restoring divide; Rsp_Valid_Out SHALL be high after edge N+4.
REQ-016 EXEC->DONE SHALL load all Rsp_* outputs together; DONE SHALL hold them stable until an edge with Rsp_Ready_In high, then DONE->IDLE.
REQ-017 Cmd_Valid_In SHALL be ignored outside IDLE; minimum command spacing SHALL be 3 cycles.
REQ-018 Arithmetic ops 0-5 SHALL compute a 5-bit result on zero-extended operands; Result = bits[3:0], Carry = bit[4] (A-1 with A=0, A-B with B>A, and B-A with A>B give Carry=1; multiply Carry = product bit 4).
REQ-019 Ops 6, 7 and all logical ops SHALL drive Carry=0; logical results SHALL be 4-bit bitwise.
REQ-020 Divide by zero SHALL give quotient 4'hF, remainder A, Div_Zero=1; Div_Zero SHALL be 0 otherwise.
REQ-021 Zero SHALL be 1 exactly when Result==0.

Reset
REQ-022 Reset assertion SHALL immediately force IDLE, counter 0, and Rsp_Valid_Out, Rsp_Result_Out, all flags and Busy_Out to 0; Cmd_Ready_Out SHALL be 1.
REQ-023 Reset mid-EXEC or in DONE SHALL discard the command; no response SHALL appear after release.

Configuration
REQ-024 With ALU_SEQ_FAST_MUL_EN defined, opcode 5 SHALL complete in one EXEC cycle using a combinational product (latency as REQ-014); without it, REQ-015 SHALL apply. Results SHALL be identical either way.

Structure
REQ-025 Package alu_seq_pkg SHALL hold the 16 opcode constants, the FSM state type, the width constant (4) and the iteration count (4).
REQ-026 Sub-module alu_seq_iter_unit SHALL hold the multiply/divide iteration datapath; the FSM and single-cycle ops SHALL stay in the top.

Verification
REQ-027 Op 2, A=9, B=8 -> Result 1, Carry 1, Zero 0, Rsp_Valid_Out one cycle after accept.
REQ-028 Op 1, A=0 -> Result F, Carry 1; op 3, A=4, B=4 -> Result 0, Zero 1, Carry 0.
REQ-029 Op 5, A=7, B=5 -> Result 3, Carry 0; valid 4 cycles after accept (1 with ALU_SEQ_FAST_MUL_EN).
REQ-030 Op 6, A=13, B=0 -> Result F, Div_Zero 1; op 7, A=13, B=0 -> Result D, Div_Zero 1; op 7, A=13, B=4 -> Result 1, Div_Zero 0.
REQ-031 Rsp_Ready_In low 3 cycles in DONE -> outputs stable, Cmd_Ready_Out 0, concurrent Cmd_Valid_In ignored; IDLE one edge after Rsp_Ready_In rises.
REQ-032 Reset_n_In low during iteration 2 of op 6 -> outputs 0 immediately, Cmd_Ready_Out 1, no Rsp_Valid_Out after release.
